// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM stage: serves one load or store after
// LATENCY cycles from an internal word array, freezing the pipeline via stall_o meanwhile.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  input  logic        memread_i,
  input  logic        memwrite_i,
  output logic [31:0] data_o,
  output logic        stall_o,
  output logic        ack_o,
  output logic        err_o
);

  localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int unsigned CNT_INIT = (LATENCY > 1) ? LATENCY - 2 : 0;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   cap_idx;
  logic [31:0]        cap_data;
  logic               cap_rd;
  logic               cap_wr;
  logic               cap_err;

  logic [31:0]        mem [DEPTH_WORDS];

  logic               req;
  logic               in_err;
  logic [IDX_W-1:0]   in_idx;
  logic               start;
  logic               finish;
  logic [IDX_W-1:0]   acc_idx;
  logic [31:0]        acc_data;
  logic               acc_rd;
  logic               acc_wr;
  logic               acc_err;
  logic               unused_addr_bits;

  // Upper address bits are deliberately ignored so accesses wrap around the array.
  assign unused_addr_bits = ^addr_i[31:IDX_W+2];

  assign req    = memread_i | memwrite_i;
  assign in_err = (addr_i[1:0] != 2'b00) | (memread_i & memwrite_i);
  assign in_idx = addr_i[IDX_W+1:2];

  // Gating with rst_i keeps the freeze request low while reset is asserted, even with req high.
  assign start  = rst_i && (state == IDLE) && req;
  assign finish = (rst_i && (state == BUSY) && (cnt == '0)) || ((LATENCY == 1) && start);

  // With LATENCY==1 the access completes on the capture edge, so it must use live inputs.
  assign acc_idx  = (state == IDLE) ? in_idx     : cap_idx;
  assign acc_data = (state == IDLE) ? data_i     : cap_data;
  assign acc_rd   = (state == IDLE) ? memread_i  : cap_rd;
  assign acc_wr   = (state == IDLE) ? memwrite_i : cap_wr;
  assign acc_err  = (state == IDLE) ? in_err     : cap_err;

  assign stall_o = start || (rst_i && (state == BUSY));

  // NOTE: the array has no reset branch; clearing it would turn a RAM into a huge register file.
  always_ff @(posedge clk_i) begin
    if (finish && acc_wr && !acc_err) begin
      mem[acc_idx] <= acc_data;
    end
  end

  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= IDLE;
      cnt      <= '0;
      cap_idx  <= '0;
      cap_data <= '0;
      cap_rd   <= 1'b0;
      cap_wr   <= 1'b0;
      cap_err  <= 1'b0;
      data_o   <= '0;
      ack_o    <= 1'b0;
      err_o    <= 1'b0;
    end else begin
      ack_o <= 1'b0;
      err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            cap_idx  <= in_idx;
            cap_data <= data_i;
            cap_rd   <= memread_i;
            cap_wr   <= memwrite_i;
            cap_err  <= in_err;
            cnt      <= CNT_W'(CNT_INIT);
            state    <= (LATENCY == 1) ? DONE : BUSY;
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            state <= DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase

      if (finish) begin
        ack_o <= 1'b1;
        err_o <= acc_err;
        if (acc_rd) begin
          data_o <= acc_err ? 32'h0 : mem[acc_idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: scoreboard of expected completions plus a
// reference word array, exercising reset abort, latency, wrap-around, errors and streaming.
module tb_dmem_responder;

  localparam int unsigned DEPTH   = 256;
  localparam int unsigned LAT     = 4;
  localparam int          MAX_CYC = 20;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic        clk;
  logic        rst_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic        memread_i;
  logic        memwrite_i;
  logic [31:0] data_o;
  logic        stall_o;
  logic        ack_o;
  logic        err_o;

  int          total;
  int          bad;
  exp_t        sb[$];
  logic [31:0] model_mem [int];
  logic [31:0] model_data;

  dmem_responder #(
    .DEPTH_WORDS(DEPTH),
    .LATENCY    (LAT)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .addr_i    (addr_i),
    .data_i    (data_i),
    .memread_i (memread_i),
    .memwrite_i(memwrite_i),
    .data_o    (data_o),
    .stall_o   (stall_o),
    .ack_o     (ack_o),
    .err_o     (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issues one request at the start of a cycle, checks the stall window and the completion.
  task automatic issue(input string name, input logic [31:0] addr, input logic [31:0] data,
                       input logic rd, input logic wr);
    exp_t e;
    int   idx;
    int   cyc;
    logic done;
    idx   = int'((addr >> 2) & (DEPTH - 1));
    e.err = (addr[1:0] != 2'b00) || (rd && wr);
    if (rd) model_data = e.err ? 32'h0 : model_mem[idx];
    if (wr && !e.err) model_mem[idx] = data;
    e.data = model_data;
    sb.push_back(e);

    @(posedge clk);
    #1;
    addr_i     = addr;
    data_i     = data;
    memread_i  = rd;
    memwrite_i = wr;

    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < MAX_CYC) begin
      @(negedge clk);
      if (ack_o === 1'b1) begin
        done = 1'b1;
      end else begin
        total++;
        if (stall_o !== 1'b1) begin
          bad++;
          $display("FAIL %s stall cycle %0d: stall_o=%b want 1", name, cyc, stall_o);
        end
        cyc++;
      end
    end

    total++;
    if (!done || cyc != LAT) begin
      bad++;
      $display("FAIL %s latency: stall cycles=%0d ack_seen=%b want %0d", name, cyc, done, LAT);
    end

    e = sb.pop_front();
    total++;
    if (stall_o !== 1'b0) begin
      bad++;
      $display("FAIL %s stall at ack: got %b want 0", name, stall_o);
    end
    total++;
    if (err_o !== e.err) begin
      bad++;
      $display("FAIL %s err_o: got %b want %b", name, err_o, e.err);
    end
    total++;
    if (data_o !== e.data) begin
      bad++;
      $display("FAIL %s data_o: got %h want %h", name, data_o, e.data);
    end
  endtask

  // Non-memory cycles: no stall, no ack, load data held.
  task automatic idle_cycles(input string name, input int n);
    @(posedge clk);
    #1;
    memread_i  = 1'b0;
    memwrite_i = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      total++;
      if (stall_o !== 1'b0 || ack_o !== 1'b0) begin
        bad++;
        $display("FAIL %s idle %0d: stall_o=%b ack_o=%b want 0 0", name, i, stall_o, ack_o);
      end
      total++;
      if (data_o !== model_data) begin
        bad++;
        $display("FAIL %s hold %0d: data_o=%h want %h", name, i, data_o, model_data);
      end
    end
  endtask

  task automatic test_reset();
    rst_i      = 1'b0;
    addr_i     = '0;
    data_i     = '0;
    memread_i  = 1'b0;
    memwrite_i = 1'b0;
    model_data = '0;
    repeat (3) @(negedge clk);
    total++;
    if ({stall_o, ack_o, err_o} !== 3'b000 || data_o !== 32'h0) begin
      bad++;
      $display("FAIL reset_state: stall=%b ack=%b err=%b data=%h want 0", stall_o, ack_o, err_o, data_o);
    end
    rst_i = 1'b1;

    issue("reset_prefill", 32'h10, 32'h0BAD_F00D, 1'b0, 1'b1);
    idle_cycles("reset_prefill", 1);

    // Start a store, then abort it with reset while it is in BUSY.
    @(posedge clk);
    #1;
    addr_i     = 32'h10;
    data_i     = 32'hDEAD_BEEF;
    memwrite_i = 1'b1;
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    #1;
    total++;
    if (stall_o !== 1'b0 || ack_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_abort: stall_o=%b ack_o=%b want 0 0", stall_o, ack_o);
    end
    memwrite_i = 1'b0;
    @(negedge clk);
    rst_i      = 1'b1;
    model_data = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      total++;
      if (ack_o !== 1'b0 || stall_o !== 1'b0) begin
        bad++;
        $display("FAIL reset_no_ack %0d: ack_o=%b stall_o=%b want 0 0", i, ack_o, stall_o);
      end
    end
    issue("reset_word4_kept", 32'h10, 32'h0, 1'b1, 1'b0);
    idle_cycles("reset_word4_kept", 1);
  endtask

  task automatic test_store_load();
    issue("store_0x20", 32'h20, 32'h1234_5678, 1'b0, 1'b1);
    issue("load_0x20", 32'h20, 32'h0, 1'b1, 1'b0);
    idle_cycles("load_0x20_held", 3);
  endtask

  task automatic test_wrap();
    issue("store_0x400", 32'h400, 32'hCAFE_0400, 1'b0, 1'b1);
    issue("load_0x000", 32'h000, 32'h0, 1'b1, 1'b0);
    issue("store_top", 32'h3FC, 32'hA5A5_03FC, 1'b0, 1'b1);
    issue("load_top_alias", 32'hFFFF_FFFC, 32'h0, 1'b1, 1'b0);
    idle_cycles("wrap", 1);
  endtask

  task automatic test_errors();
    issue("prefill_0x24", 32'h24, 32'h1111_1111, 1'b0, 1'b1);
    issue("load_nonzero", 32'h20, 32'h0, 1'b1, 1'b0);
    issue("misaligned_load", 32'h22, 32'h0, 1'b1, 1'b0);
    issue("misaligned_store", 32'h25, 32'h7777_7777, 1'b0, 1'b1);
    issue("rd_wr_both", 32'h24, 32'h5555_5555, 1'b1, 1'b1);
    issue("check_0x24", 32'h24, 32'h0, 1'b1, 1'b0);
    idle_cycles("errors", 1);
  endtask

  // Pipeline-like sequence: add (no memory), lw, lw, sw back to back, then load the stored word.
  task automatic test_back_to_back();
    issue("b2b_prefill", 32'h30, 32'h0000_0042, 1'b0, 1'b1);
    idle_cycles("b2b_add", 2);
    issue("b2b_lw1", 32'h30, 32'h0, 1'b1, 1'b0);
    issue("b2b_lw2", 32'h24, 32'h0, 1'b1, 1'b0);
    issue("b2b_sw", 32'h34, 32'hFACE_B00C, 1'b0, 1'b1);
    issue("b2b_raw", 32'h34, 32'h0, 1'b1, 1'b0);
    idle_cycles("b2b_tail", 2);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_store_load();
    test_wrap();
    test_errors();
    test_back_to_back();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_empty: left=%0d want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
